// File: rtl/mem_bus_decoder_if.sv
// -----------------------------------------------------------------------------
// mem_bus_decoder_if
// Bundles the picorv32 native request/response and the shared slave bus that
// the mem_bus_decoder sits between.
//   master modport : the decoder's view (takes CPU requests and slave
//                    responses, drives CPU responses and the slave request).
//   slave modport  : the surrounding system's view (CPU plus slaves).
// Signals:
//   cpu_valid/cpu_addr/cpu_wdata/cpu_wstrb : CPU request
//   cpu_ready/cpu_rdata                    : CPU response
//   s_sel/s_addr/s_wdata/s_wstrb           : slave request, qualified by s_sel
//   s_ready/s_rdata                        : slave responses, slave i at
//                                            s_rdata[32i+31:32i]
// -----------------------------------------------------------------------------
interface mem_bus_decoder_if #(
    parameter int NUM_SLAVES = 8
);
    logic                      cpu_valid;
    logic [31:0]               cpu_addr;
    logic [31:0]               cpu_wdata;
    logic [3:0]                cpu_wstrb;
    logic                      cpu_ready;
    logic [31:0]               cpu_rdata;

    logic [NUM_SLAVES-1:0]     s_sel;
    logic [31:0]               s_addr;
    logic [31:0]               s_wdata;
    logic [3:0]                s_wstrb;
    logic [NUM_SLAVES-1:0]     s_ready;
    logic [NUM_SLAVES*32-1:0]  s_rdata;

    modport master (
        input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb, s_ready, s_rdata,
        output cpu_ready, cpu_rdata, s_sel, s_addr, s_wdata, s_wstrb
    );

    modport slave (
        output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb, s_ready, s_rdata,
        input  cpu_ready, cpu_rdata, s_sel, s_addr, s_wdata, s_wstrb
    );
endinterface

// File: rtl/mem_bus_decoder.sv
// -----------------------------------------------------------------------------
// mem_bus_decoder
// Routes one picorv32 native-bus request at a time to one of NUM_SLAVES
// slaves, selected by the 4-bit address field [SEL_LO+3:SEL_LO]. Slaves marked
// in SYNC_MASK are 1-cycle-read memories (write strobe in the first ACCESS
// cycle, read data taken in the second); the others handshake with s_ready.
// Unmapped indices answer immediately with ERR_RDATA.
//
// Optional feature, macro BUS_TIMEOUT_EN: an ACCESS that has not completed
// after TIMEOUT_CYCLES cycles is abandoned with ERR_RDATA, and timeouts and
// unmapped accesses are recorded in fault/fault_addr (cleared by fault_clr).
// Without the macro the decoder waits forever and fault/fault_addr read 0.
//
// Ports:
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   bus        : CPU request/response and shared slave bus (master modport)
//   fault      : sticky bus-fault flag
//   fault_addr : address of the most recent faulting access
//   fault_clr  : clears fault (a fault raised in the same cycle wins)
// -----------------------------------------------------------------------------
module mem_bus_decoder #(
    parameter int                    NUM_SLAVES     = 8,
    parameter int                    SEL_LO         = 12,
    parameter logic [NUM_SLAVES-1:0] SYNC_MASK      = NUM_SLAVES'(8'b0000_0111),
    parameter int                    TIMEOUT_CYCLES = 255,
    parameter logic [31:0]           ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    mem_bus_decoder_if.master        bus,
    output logic                     fault,
    output logic [31:0]              fault_addr,
    input  logic                     fault_clr
);

    localparam int         SW           = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [4:0] NUM_SLAVES_W = 5'(NUM_SLAVES);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t          state_q, state_d;
    logic [31:0]     addr_q, wdata_q, rdata_q;
    logic [3:0]      wstrb_q;
    logic [SW-1:0]   idx_q;
    logic            first_q;     // first cycle of the current ACCESS
    logic            done;        // slave completes in this ACCESS cycle
    logic            timeout;     // ACCESS abandoned in this cycle

    logic [3:0]      idx_in;
    logic            mapped_in;
    logic            is_sync;
    logic [31:0]     slave_rdata [NUM_SLAVES];

    assign idx_in    = bus.cpu_addr[SEL_LO +: 4];
    assign mapped_in = ({1'b0, idx_in} < NUM_SLAVES_W);
    assign is_sync   = SYNC_MASK[idx_q];

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_rdata
        assign slave_rdata[g] = bus.s_rdata[32*g +: 32];
    end

`ifdef BUS_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;
`endif

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- next state ----------------
    // NOTE: every variable gets a default before the case, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cpu_valid) state_d = mapped_in ? ACCESS : RESP;
            end
            ACCESS: begin
                // Sync memories answer in the cycle after the strobe cycle;
                // their s_ready is not looked at.
                if (is_sync ? !first_q : bus.s_ready[idx_q]) begin
                    done    = 1'b1;
                    state_d = RESP;
                end
`ifdef BUS_TIMEOUT_EN
                else if (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    timeout = 1'b1;
                    state_d = RESP;
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- request latch and response capture ----------------
    // NOTE: all datapath registers are reset, because the latched address and
    // captured data drive outputs that must read 0 while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            idx_q   <= '0;
            first_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cpu_valid) begin
                        addr_q  <= bus.cpu_addr;
                        wdata_q <= bus.cpu_wdata;
                        wstrb_q <= bus.cpu_wstrb;
                        idx_q   <= idx_in[SW-1:0];
                        first_q <= 1'b1;
                        rdata_q <= mapped_in ? 32'h0 : ERR_RDATA;
                    end
                end
                ACCESS: begin
                    first_q <= 1'b0;
                    if (done)         rdata_q <= slave_rdata[idx_q];
                    else if (timeout) rdata_q <= ERR_RDATA;
                end
                default: ;
            endcase
        end
    end

`ifdef BUS_TIMEOUT_EN
    // ---------------- timeout counter and fault status ----------------
    logic        fault_q;
    logic [31:0] fault_addr_q;
    logic        fault_set;

    // An unmapped request is flagged as it is accepted, before addr_q holds it.
    assign fault_set = (state_q == IDLE && bus.cpu_valid && !mapped_in) || timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 tmo_cnt_q <= '0;
        else if (state_q == IDLE)   tmo_cnt_q <= '0;
        else if (state_q == ACCESS) tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else if (fault_set) begin
            fault_q      <= 1'b1;
            fault_addr_q <= (state_q == IDLE) ? bus.cpu_addr : addr_q;
        end else if (fault_clr) begin
            fault_q      <= 1'b0;
        end
    end

    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;
`else
    logic unused_fault_clr;
    assign unused_fault_clr = fault_clr;
    assign fault            = 1'b0;
    assign fault_addr       = '0;
`endif

    // ---------------- outputs ----------------
    always_comb begin
        bus.s_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (state_q == ACCESS && idx_q == SW'(i)) bus.s_sel[i] = 1'b1;
        end
    end

    // Sync memories see the strobe in their first ACCESS cycle only, so the
    // read cycle that follows cannot write twice.
    assign bus.s_wstrb   = (state_q == ACCESS && (!is_sync || first_q)) ? wstrb_q : 4'h0;
    assign bus.s_addr    = addr_q;
    assign bus.s_wdata   = wdata_q;
    assign bus.cpu_ready = (state_q == RESP);
    assign bus.cpu_rdata = (state_q == RESP) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_mem_bus_decoder.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_decoder
// Drives directed and randomized CPU transactions through mem_bus_decoder and
// compares every cycle against a transaction-level model: from the address,
// the sync mask and the chosen slave response delay it predicts latency,
// per-cycle slave select/strobe, returned data and fault status.
// Build with BUS_TIMEOUT_EN defined to also exercise the timeout/fault path.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_bus_decoder;

    localparam int          NS     = 8;
    localparam int          SEL_LO = 12;
    localparam logic [7:0]  MASK   = 8'b0000_0111;
    localparam int          TMO    = 4;
    localparam logic [31:0] ERR    = 32'hDEAD_BEEF;
    localparam int          BUDGET = 20;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        fault_clr = 1'b0;
    logic        fault;
    logic [31:0] fault_addr;

    mem_bus_decoder_if #(.NUM_SLAVES(NS)) bus ();

    mem_bus_decoder #(
        .NUM_SLAVES    (NS),
        .SEL_LO        (SEL_LO),
        .SYNC_MASK     (MASK),
        .TIMEOUT_CYCLES(TMO),
        .ERR_RDATA     (ERR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .fault     (fault),
        .fault_addr(fault_addr),
        .fault_clr (fault_clr)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        exp_fault = 1'b0;
    logic [31:0] exp_faddr = 32'h0;
    logic [7:0]  mask_v    = MASK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Random responses on every slave except `sel`; sel's ready is forced.
    task automatic drive_slaves(input int sel, input logic sel_ready);
        for (int i = 0; i < NS; i++) begin
            if (i != sel) begin
                bus.s_ready[i]          = 1'($urandom);
                bus.s_rdata[i*32 +: 32] = $urandom;
            end
        end
        if (sel < NS) bus.s_ready[sel] = sel_ready;
    endtask

    // One CPU transaction. k = ACCESS cycle in which an async slave raises
    // s_ready (0 = never). clr0 pulses fault_clr alongside the request.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int k,
                           input logic [31:0] sdata, input bit clr0);
        int          idx;
        int          lat;
        bit          mapped, sync, err, done;
        logic [31:0] exp_rd;
        logic [7:0]  exp_sel;
        logic [3:0]  exp_strb;

        idx    = int'(addr[SEL_LO +: 4]);
        mapped = (idx < NS);
        sync   = mapped && mask_v[idx];
        err    = 1'b0;
        exp_sel = 8'h0;
        if (mapped) exp_sel[idx] = 1'b1;

        if (!mapped) begin
            lat = 1; exp_rd = ERR; err = 1'b1;
        end else if (sync) begin
            lat = 3; exp_rd = sdata;
`ifdef BUS_TIMEOUT_EN
        end else if (k >= 1 && k <= TMO) begin
            lat = k + 1; exp_rd = sdata;
        end else begin
            lat = TMO + 1; exp_rd = ERR; err = 1'b1;
`else
        end else begin
            lat = k + 1; exp_rd = sdata;
`endif
        end

        @(negedge clk);
        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        bus.cpu_wstrb = wstrb;
        fault_clr     = clr0;
        if (mapped) bus.s_rdata[idx*32 +: 32] = sdata;
        drive_slaves(idx, sync ? 1'($urandom) : 1'b0);

        done = 1'b0;
        for (int c = 1; c <= BUDGET && !done; c++) begin
            @(negedge clk);
            if (c == 1 && clr0) exp_fault = 1'b0;
`ifdef BUS_TIMEOUT_EN
            if (c == lat && err) begin
                exp_fault = 1'b1;
                exp_faddr = addr;
            end
`endif
            check("cpu_ready", bus.cpu_ready, (c == lat));
            check("fault", fault, exp_fault);
            check("fault_addr", fault_addr, exp_faddr);
            if (bus.cpu_ready) begin
                check("cpu_rdata", bus.cpu_rdata, exp_rd);
                check("s_sel_resp", bus.s_sel, 8'h0);
                check("s_wstrb_resp", bus.s_wstrb, 4'h0);
                bus.cpu_valid = 1'b0;
                done = 1'b1;
            end else begin
                check("cpu_rdata_zero", bus.cpu_rdata, 32'h0);
                if (c < lat) begin
                    exp_strb = (sync && c != 1) ? 4'h0 : wstrb;
                    check("s_sel", bus.s_sel, exp_sel);
                    check("s_wstrb", bus.s_wstrb, exp_strb);
                    check("s_addr", bus.s_addr, addr);
                    check("s_wdata", bus.s_wdata, wdata);
                end
            end
            fault_clr = 1'b0;
            drive_slaves(idx, sync ? 1'($urandom) : (c == k));
        end
        check("txn_budget", done, 1'b1);
        bus.cpu_valid = 1'b0;

        @(negedge clk);
        check("idle_ready", bus.cpu_ready, 1'b0);
        check("idle_s_sel", bus.s_sel, 8'h0);
    endtask

    task automatic clear_fault();
        @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        exp_fault = 1'b0;
        check("fault_cleared", fault, exp_fault);
        check("fault_addr_kept", fault_addr, exp_faddr);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int          idx, k;
        logic [31:0] addr;

        bus.cpu_valid = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.cpu_wstrb = '0;
        bus.s_ready   = '0;
        bus.s_rdata   = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_cpu_ready", bus.cpu_ready, 1'b0);
        check("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
        check("rst_s_sel", bus.s_sel, 8'h0);
        check("rst_s_wstrb", bus.s_wstrb, 4'h0);
        check("rst_s_addr", bus.s_addr, 32'h0);
        check("rst_fault", fault, 1'b0);
        check("rst_fault_addr", fault_addr, 32'h0);
        rst_n = 1'b1;

        // Sync read from slave 1.
        run_txn(32'h0000_1004, 32'h0, 4'h0, 0, 32'h1234_5678, 1'b0);
        // Async write to slave 4, ready in the 5th ACCESS cycle.
        run_txn(32'h0000_4000, 32'h41, 4'h1, 5, $urandom, 1'b0);
        // Sync write to slave 0: strobe only in the first ACCESS cycle.
        run_txn(32'h0000_0010, 32'hCAFE_F00D, 4'hF, 0, $urandom, 1'b0);
        // Unmapped index 9.
        run_txn(32'h0000_9000, 32'h0, 4'h0, 0, $urandom, 1'b0);
        clear_fault();
        // Async read, ready in the first ACCESS cycle.
        run_txn(32'h0000_7abc, 32'h0, 4'h0, 1, $urandom, 1'b0);

`ifdef BUS_TIMEOUT_EN
        // Slave 5 never answers: timeout with error data and a fault record.
        run_txn(32'h0000_5000, 32'h0, 4'h0, 0, $urandom, 1'b0);
        check("tmo_fault_addr", fault_addr, 32'h0000_5000);
        clear_fault();
        // fault_clr in the same cycle as a new unmapped fault: the fault wins.
        run_txn(32'h0000_A004, 32'h0, 4'h0, 0, $urandom, 1'b1);
        clear_fault();
`endif

        // Reset in the middle of an async write.
        @(negedge clk);
        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = 32'h0000_4000;
        bus.cpu_wdata = 32'h55;
        bus.cpu_wstrb = 4'h3;
        bus.s_ready   = '0;
        @(negedge clk);
        check("abort_s_sel", bus.s_sel, 8'h10);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_rst_s_sel", bus.s_sel, 8'h0);
        check("abort_rst_ready", bus.cpu_ready, 1'b0);
        check("abort_rst_wstrb", bus.s_wstrb, 4'h0);
        check("abort_rst_fault", fault, 1'b0);
        bus.cpu_valid = 1'b0;
        exp_fault = 1'b0;
        exp_faddr = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(32'h0000_2008, 32'h0, 4'h0, 0, 32'hA5A5_0F0F, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            idx  = $urandom_range(0, 11);
            addr = {16'($urandom), 4'(idx), 12'($urandom)};
`ifdef BUS_TIMEOUT_EN
            k = $urandom_range(0, 6);
`else
            k = $urandom_range(1, 6);
`endif
            run_txn(addr, $urandom, 4'($urandom), k, $urandom,
                    ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 9) == 0) clear_fault();
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
